// File: rtl/retime_pipe.sv
`default_nettype none
// ============================================================================
// Module   : retime_pipe
// Brief    : Elastic retiming pipeline with per-stage optional inversion and
//            bubble collapsing. Define RETIME_PIPE_OCC_EN to add OCCUPANCY.
// Revision : 1.0 - initial release
// ============================================================================
module retime_pipe #(
  parameter int               WIDTH    = 1,
  parameter int               DEPTH    = 8,
  parameter logic [DEPTH-1:0] INV_MASK = '0,
  parameter logic             OUT_INV  = 1'b1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY
`ifdef RETIME_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] OCCUPANCY
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            w_adv;

  // A stage advances when it is empty or the stage after it advances, so any
  // hole downstream lets every stage upstream of it move (bubble collapse).
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = OUT_READY | ~r_valid[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      w_adv[k] = w_adv[k+1] | ~r_valid[k];
    end
  end

  assign IN_READY  = ~RESET & w_adv[0];
  assign OUT_VALID = r_valid[DEPTH-1];
  assign OUT       = r_data[DEPTH-1] ^ {WIDTH{OUT_INV}};

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_data  <= '0;
      r_valid <= '0;
    end else begin
      if (w_adv[0]) begin
        r_data[0]  <= IN ^ {WIDTH{INV_MASK[0]}};
        r_valid[0] <= IN_VALID;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_adv[k]) begin
          r_data[k]  <= r_data[k-1] ^ {WIDTH{INV_MASK[k]}};
          r_valid[k] <= r_valid[k-1];
        end
      end
    end
  end

`ifdef RETIME_PIPE_OCC_EN
  localparam int c_OCC_W = $clog2(DEPTH + 1);

  logic [c_OCC_W-1:0] r_occ;
  logic               w_acc;
  logic               w_drain;

  assign w_acc   = IN_VALID & IN_READY;
  assign w_drain = OUT_VALID & OUT_READY;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_occ <= '0;
    end else if (w_acc & ~w_drain) begin
      r_occ <= r_occ + c_OCC_W'(1);
    end else if (~w_acc & w_drain) begin
      r_occ <= r_occ - c_OCC_W'(1);
    end
  end

  assign OCCUPANCY = r_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_retime_pipe.sv
`default_nettype none
// tb_retime_pipe: three retime_pipe configurations checked every cycle against a
// word/position model, plus directed literal checks of latency, inversion, stalls and reset.
module tb_retime_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][3:0] din;
  logic [2:0]      iv;
  logic [2:0]      ordy;

  logic [3:0] a_out, b_out;
  logic       c_out;
  logic       a_ov, b_ov, c_ov, a_ir, b_ir, c_ir;
`ifdef RETIME_PIPE_OCC_EN
  logic [2:0] a_occ, b_occ;
  logic [0:0] c_occ;
`endif

  retime_pipe #(.WIDTH(4), .DEPTH(4), .INV_MASK(4'b0000), .OUT_INV(1'b0)) u_a (
    .CLOCK(clk), .RESET(rst), .IN(din[0]), .IN_VALID(iv[0]), .IN_READY(a_ir),
    .OUT(a_out), .OUT_VALID(a_ov), .OUT_READY(ordy[0])
`ifdef RETIME_PIPE_OCC_EN
    , .OCCUPANCY(a_occ)
`endif
  );

  retime_pipe #(.WIDTH(4), .DEPTH(4), .INV_MASK(4'b0001), .OUT_INV(1'b1)) u_b (
    .CLOCK(clk), .RESET(rst), .IN(din[1]), .IN_VALID(iv[1]), .IN_READY(b_ir),
    .OUT(b_out), .OUT_VALID(b_ov), .OUT_READY(ordy[1])
`ifdef RETIME_PIPE_OCC_EN
    , .OCCUPANCY(b_occ)
`endif
  );

  retime_pipe #(.WIDTH(1), .DEPTH(1), .INV_MASK(1'b0), .OUT_INV(1'b1)) u_c (
    .CLOCK(clk), .RESET(rst), .IN(din[2][0]), .IN_VALID(iv[2]), .IN_READY(c_ir),
    .OUT(c_out), .OUT_VALID(c_ov), .OUT_READY(ordy[2])
`ifdef RETIME_PIPE_OCC_EN
    , .OCCUPANCY(c_occ)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int act_out(input int d);
    if (d == 0) return int'(a_out);
    if (d == 1) return int'(b_out);
    return int'(c_out);
  endfunction
  function automatic int act_ov(input int d);
    if (d == 0) return int'(a_ov);
    if (d == 1) return int'(b_ov);
    return int'(c_ov);
  endfunction
  function automatic int act_ir(input int d);
    if (d == 0) return int'(a_ir);
    if (d == 1) return int'(b_ir);
    return int'(c_ir);
  endfunction
`ifdef RETIME_PIPE_OCC_EN
  function automatic int act_occ(input int d);
    if (d == 0) return int'(a_occ);
    if (d == 1) return int'(b_occ);
    return int'(c_occ);
  endfunction
`endif

  // Model: each DUT holds an ordered list of words (oldest first) with stage positions.
  int dep[3]  = '{4, 4, 1};
  int wm[3]   = '{15, 15, 1};
  int xr[3]   = '{0, 0, 1};   // net inversion: parity of INV_MASK xor OUT_INV
  int oinv[3] = '{0, 15, 1};  // OUT while in reset
  int mdat[3][33];
  int mpos[3][33];
  int mn[3] = '{0, 0, 0};

  // Moves every word one stage forward where the next stage is free or being vacated.
  // Returns whether stage 0 is free afterwards (input acceptance).
  function automatic bit model_move(input int d, input bit commit);
    int np[33];
    int nd[33];
    int k = 0;
    int prev = dep[d] + 1;
    for (int i = 0; i < mn[d]; i++) begin
      int p = mpos[d][i];
      if (p == dep[d] - 1 && ordy[d]) begin
        prev = dep[d];
      end else begin
        if (p < dep[d] - 1 && prev > p + 1) p++;
        np[k] = p;
        nd[k] = mdat[d][i];
        k++;
        prev = p;
      end
    end
    if (commit) begin
      mn[d] = k;
      for (int i = 0; i < k; i++) begin
        mpos[d][i] = np[i];
        mdat[d][i] = nd[i];
      end
    end
    return (k == 0) || (np[k-1] > 0);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        bit r;
        r = model_move(d, 1'b1);
        if (iv[d] && r) begin
          mdat[d][mn[d]] = int'(din[d]) & wm[d];
          mpos[d][mn[d]] = 0;
          mn[d]++;
        end
      end
    end
  end

  always @(posedge rst) begin
    for (int d = 0; d < 3; d++) mn[d] = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int eov;
      eov = (mn[d] > 0 && mpos[d][0] == dep[d] - 1) ? 1 : 0;
      chk($sformatf("m%0d_out_valid", d), act_ov(d), eov);
      if (eov != 0)
        chk($sformatf("m%0d_out_data", d), act_out(d), mdat[d][0] ^ ((xr[d] != 0) ? wm[d] : 0));
      chk($sformatf("m%0d_in_ready", d), act_ir(d), rst ? 0 : int'(model_move(d, 1'b0)));
      if (rst) chk($sformatf("m%0d_rst_out", d), act_out(d), oinv[d]);
`ifdef RETIME_PIPE_OCC_EN
      chk($sformatf("m%0d_occupancy", d), act_occ(d), mn[d]);
`endif
    end
  end

  int vals[3] = '{0, 5, 15};

  initial begin
    int acc;
    int prevb;
    iv   = '0;
    ordy = '1;
    din  = '0;

    // reset state, then latency on A with reset released between edges
    #12;
    chk("rst_ov_a", a_ov, 0);
    chk("rst_ir_a", a_ir, 0);
    chk("rst_out_b", b_out, 15);
    chk("rst_out_c", c_out, 1);
    rst = 1'b0;
    din[0] = 4'hA;
    iv[0]  = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      chk("lat_ov", a_ov, (cyc == 4) ? 1 : 0);
      if (cyc == 4) chk("lat_out", a_out, 10);
    end

    // inversion on B: mask and output inversion cancel
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      din[1] = 4'(vals[j]);
      iv[1]  = 1'b1;
      @(posedge clk); #1;
    end
    iv[1] = 1'b0;
    for (int cyc = 3; cyc <= 7; cyc++) begin
      @(negedge clk);
      chk("inv_ov", b_ov, (cyc >= 4 && cyc <= 6) ? 1 : 0);
      if (cyc >= 4 && cyc <= 6) chk("inv_out", b_out, vals[cyc-4]);
    end

    // backpressure on A
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      din[0] = 4'(acc + 1);
      iv[0]  = 1'b1;
      @(negedge clk);
      if (a_ir) acc++;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    chk("bp_accepted", acc, 4);
    @(negedge clk);
    chk("bp_ir_low", a_ir, 0);
`ifdef RETIME_PIPE_OCC_EN
    chk("bp_occ", a_occ, 4);
`endif
    #1 ordy[0] = 1'b1;
    #1;
    chk("bp_ir_drain", a_ir, 1);
    chk("bp_out0", a_out, 1);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      chk("bp_ov", a_ov, 1);
      chk("bp_out", a_out, j + 1);
    end
    @(negedge clk);
    chk("bp_ov_end", a_ov, 0);

    // bubble collapse on A
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    din[0]  = 4'h3;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    din[0] = 4'h9;
    iv[0]  = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bub_ir", a_ir, 1);
    chk("bub_head", a_out, 3);
`ifdef RETIME_PIPE_OCC_EN
    chk("bub_occ", a_occ, 2);
`endif
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bub_first", a_out, 3);
    @(negedge clk);
    chk("bub_second_ov", a_ov, 1);
    chk("bub_second", a_out, 9);
    @(negedge clk);
    chk("bub_end", a_ov, 0);

    // asynchronous reset with three words in flight on A
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      din[0] = 4'(j + 5);
      iv[0]  = 1'b1;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mrst_ov", a_ov, 0);
    chk("mrst_out", a_out, 0);
    chk("mrst_ir", a_ir, 0);
    chk("mrst_out_b", b_out, 15);
`ifdef RETIME_PIPE_OCC_EN
    chk("mrst_occ", a_occ, 0);
`endif
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("mrst_no_stale", a_ov, 0);
    end

    // DEPTH=1 inverter on C
    @(posedge clk); #1;
    prevb = 0;
    for (int j = 0; j < 8; j++) begin
      din[2] = 4'(j % 2);
      iv[2]  = 1'b1;
      @(negedge clk);
      if (j > 0) begin
        chk("d1_ov", c_ov, 1);
        chk("d1_out", c_out, 1 - prevb);
      end
      prevb = j % 2;
      @(posedge clk); #1;
    end
    iv[2] = 1'b0;

    // randomized traffic on all three, with one asynchronous reset pulse
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      if (n == 700) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      for (int d = 0; d < 3; d++) begin
        iv[d]   = ($urandom_range(0, 3) != 0);
        din[d]  = 4'($urandom_range(0, 15));
        ordy[d] = (n % 300 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      end
    end
    @(posedge clk); #1;
    iv = '0;
    ordy = '1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/retime_pipe.md
RETIME_PIPE -- requirements
Module: retime_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data bits per stage (legal range 1..64).
REQ-002 SHALL have parameter DEPTH, default 8, number of register stages (legal range 1..32).
REQ-003 SHALL have parameter INV_MASK, default 0, DEPTH bits; bit k set means stage k stores the inverted value of its input.
REQ-004 SHALL have parameter OUT_INV, default 1, 1 bit; when set, OUT is the inverted value of the last stage.
REQ-005 SHALL have port CLOCK  input  1  single rising-edge clock for all state.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port IN  input  WIDTH  input data.
REQ-008 SHALL have port IN_VALID  input  1  IN holds a word.
REQ-009 SHALL have port IN_READY  output  1  block accepts IN this cycle.
REQ-010 SHALL have port OUT  output  WIDTH  output data.
REQ-011 SHALL have port OUT_VALID  output  1  OUT holds a word.
REQ-012 SHALL have port OUT_READY  input  1  downstream consumes OUT this cycle.

Function
REQ-013 SHALL hold a chain of DEPTH stages, stage 0 nearest IN; each stage has a WIDTH-bit data register and a valid bit.
REQ-014 SHALL treat a transfer as occurring on a rising CLOCK edge where valid and ready are both high on that side.
REQ-015 SHALL load stage k with its source value XOR {WIDTH{INV_MASK[k]}}; the source is IN for k=0 and stage k-1 data otherwise.
REQ-016 SHALL drive OUT = stage DEPTH-1 data XOR {WIDTH{OUT_INV}}, and OUT_VALID = stage DEPTH-1 valid, both combinationally.
REQ-017 SHALL let stage k advance (capture its source and copy the source valid bit) when stage k is empty or stage k is draining in the same cycle; stage DEPTH-1 drains when OUT_READY=1.
REQ-018 SHALL collapse bubbles: an empty stage SHALL accept a word from a valid upstream stage even while a later stage is stalled.
REQ-019 SHALL drive IN_READY = (stage 0 empty) OR (stage 0 advancing this cycle); IN_READY may depend combinationally on OUT_READY.
REQ-020 SHALL give a latency of exactly DEPTH cycles from IN acceptance to OUT_VALID when OUT_READY is held at 1.
REQ-021 SHALL sustain one word per cycle when OUT_READY is held at 1, including when all DEPTH stages are valid.
REQ-022 SHALL hold OUT and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL deassert IN_READY when all stages are valid and OUT_READY=0.
REQ-024 SHALL keep the contents of a stage unchanged when it is not advancing; a stage whose valid bit is clear is don't-care only for ordering purposes, never for OUT while OUT_VALID=1.
REQ-025 SHALL ignore IN when IN_VALID=0, and SHALL never drop, duplicate or reorder words.

Reset
REQ-026 SHALL, while RESET=1 and independent of CLOCK, clear every stage valid bit and every stage data register to 0.
REQ-027 SHALL, during reset, drive OUT_VALID=0, IN_READY=0 and OUT={WIDTH{OUT_INV}}.
REQ-028 SHALL discard in-flight words when RESET is asserted mid-operation, and SHALL accept input on the first rising edge after RESET deasserts.

Configuration
REQ-029 SHALL, when macro RETIME_PIPE_OCC_EN is defined, add output port OCCUPANCY, width $clog2(DEPTH+1), giving the registered count of valid stages (0 on reset, updated on each edge by +1 on accept, -1 on drain, unchanged when both or neither occur).
REQ-030 SHALL, when RETIME_PIPE_OCC_EN is undefined, have no OCCUPANCY port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover latency: WIDTH=4, DEPTH=4, INV_MASK=0, OUT_INV=0, OUT_READY=1, IN=4'hA valid for 1 cycle -> OUT_VALID rises 4 cycles later with OUT=4'hA for exactly 1 cycle.
REQ-032 SHALL cover inversion: DEPTH=4, INV_MASK=4'b0001, OUT_INV=1, stream 4'h0,4'h5,4'hF -> OUT streams 4'h0,4'h5,4'hF (two inversions cancel).
REQ-033 SHALL cover backpressure: OUT_READY=0, 6 words offered with IN_VALID=1 -> exactly 4 accepted, IN_READY=0 afterwards, OCCUPANCY=4 (macro on); then OUT_READY=1 -> the 4 words emit in order on consecutive cycles and IN_READY=1 on the first drain cycle.
REQ-034 SHALL cover bubble collapse: one word, stall OUT_READY=0 for 10 cycles, then a second word -> the second word reaches stage 2 while the first word waits at stage 3, and both exit back-to-back once OUT_READY=1.
REQ-035 SHALL cover reset mid-operation: 3 words in flight, RESET pulsed asynchronously between edges -> OUT_VALID=0 and OUT={WIDTH{OUT_INV}} immediately, OCCUPANCY=0, and no stale word ever emerges.
REQ-036 SHALL cover DEPTH=1, WIDTH=1, OUT_INV=1: toggling IN with OUT_READY=1 -> OUT is the inverse of IN delayed by 1 cycle.
